config_chain_loader: RTL and testbench
======================================

// Module: config_chain_loader
// PURPOSE
//  Sequences the programming of a configuration chain of CHAIN_LEN DFF cells.
//  Accepts bitstream words over a valid/ready handshake and serialises them LSB-first onto the chain head.
//  Emits a one-cycle chain clock-enable per bit and signals completion.
//  Sits between the bitstream source (test bench, or the JTAG/SPI front end) and the CCFF chain of the fabric.
// PARAMETERS
//  CHAIN_LEN  64  number of DFF cells in the chain (>=1)
//  WORD_W     8   bitstream word width (>=1)
//  CNT_W      $clog2(CHAIN_LEN+1)  derived width of the bit counter; not overridden
// PORTS
//  CK        in   1       single clock, rising edge
//  RSTN      in   1       reset, asynchronous, active-low
//  START     in   1       pulse: begin a load (honoured in IDLE or DONE only)
//  ABORT     in   1       pulse: cancel the load, return to IDLE
//  IN_DATA   in   WORD_W  bitstream word; bit 0 is shifted first
//  IN_VALID  in   1       IN_DATA valid
//  IN_READY  out  1       block accepts IN_DATA this cycle
//  HEAD      out  1       serial data to the chain head (registered)
//  SHIFT_EN  out  1       chain clock-enable; chain captures HEAD on the CK edge where SHIFT_EN=1 (registered)
//  BUSY      out  1       high in LOAD state
//  DONE      out  1       high in DONE state
//  BITS_LEFT out  CNT_W   bits still to be issued in the current load
// BEHAVIOUR
//  Reset (RSTN=0, async): state=IDLE; HEAD=0; SHIFT_EN=0; BUSY=0; DONE=0; BITS_LEFT=0; IN_READY=0;
//    shift register and word bit count cleared.
//  States: IDLE -> LOAD on START. LOAD -> FLUSH on the edge that issues bit CHAIN_LEN. FLUSH -> DONE on the next edge.
//    DONE -> LOAD on START. Any state -> IDLE on ABORT.
//  Priority: ABORT over START, and ABORT over all LOAD activity.
//  START in LOAD or FLUSH is ignored.
//  On entry to LOAD: BITS_LEFT=CHAIN_LEN; DONE=0; word bit count wb=0.
//  IN_READY is combinational: state==LOAD && BITS_LEFT>wb && (wb==0 || (wb==1 && SHIFT issuing this edge)).
//    The ready condition overlaps the last bit of the current word, so a continuous stream has no bubble.
//  Word accept (IN_VALID && IN_READY at edge):
//    - shreg<=IN_DATA;
//    - wb<=min(WORD_W, BITS_LEFT - bits issued this edge).
//  Per-edge issue (LOAD and wb>0):
//    - HEAD<=shreg[0]; SHIFT_EN<=1; shreg>>=1; wb-=1; BITS_LEFT-=1.
//    - Exactly one bit per cycle while data is available.
//  Stall (LOAD, wb==0, no accept): SHIFT_EN<=0, HEAD holds. No timeout; the block waits indefinitely.
//  Final word:
//    - Bits beyond the remaining count are discarded.
//    - IN_READY stays 0 once all CHAIN_LEN bits are held or issued; extra words are never accepted.
//  Latency: word accepted at edge t -> bit0 on HEAD with SHIFT_EN=1 after edge t+1.
//  Completion:
//    - SHIFT_EN for the last bit is high in the FLUSH cycle.
//    - At the next edge: SHIFT_EN<=0 and DONE<=1.
//    - DONE holds until START or ABORT.
//  SHIFT_EN pulse count per load is exactly CHAIN_LEN; no pulse is issued outside LOAD/FLUSH.
//  ABORT:
//    - Next edge: state=IDLE, SHIFT_EN=0, HEAD=0, DONE=0, BITS_LEFT=0, shreg/wb cleared.
//    - The chain is left partially programmed; a fresh START is required.
//  Async reset mid-load behaves as ABORT but takes effect immediately, without waiting for an edge.
//  CHAIN_LEN < WORD_W: one word is consumed and its upper bits are discarded.
// TESTING
//  T1 reset: RSTN=0 mid-stream -> all outputs 0 immediately; after release, state=IDLE and IN_READY=0.
//  T2 CHAIN_LEN=20, WORD_W=8, words 0xA5,0x3C,0xFF continuous:
//     - exactly 3 accepts; 20 consecutive SHIFT_EN pulses;
//     - HEAD sequence = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1;
//     - DONE=1 one cycle after the last pulse.
//  T3 same config, IN_VALID dropped for 5 cycles after word 1:
//     - SHIFT_EN gap of 5 cycles; HEAD sequence unchanged;
//     - BITS_LEFT frozen at 12 during the gap.
//  T4 ABORT asserted after 10 bits: next edge SHIFT_EN=0, BITS_LEFT=0, DONE=0;
//     a new START then produces 20 fresh pulses.
//  T5 START and ABORT together in IDLE -> stays IDLE.
//     START during LOAD -> ignored; pulse count still 20.
//  T6 after DONE, hold IN_VALID=1 -> IN_READY stays 0; START -> BITS_LEFT=20 and DONE=0 on the next edge.

Source files
------------

// File: rtl/config_chain_loader.sv
// Configuration chain loader: takes bitstream words over a valid/ready handshake
// and shifts them LSB-first onto a CCFF chain, one bit per enabled chain clock.
module config_chain_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              ABORT,
  input  logic [WORD_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              HEAD,
  output logic              SHIFT_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  BITS_LEFT
);

  // A word never holds more useful bits than the whole chain.
  localparam int unsigned WordCap = (WORD_W < CHAIN_LEN) ? WORD_W : CHAIN_LEN;
  localparam logic [CNT_W-1:0] WordCapC  = CNT_W'(WordCap);
  localparam logic [CNT_W-1:0] ChainLenC = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] OneC      = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic                head_q, head_d;
  logic                shift_en_q, shift_en_d;
  logic [CNT_W-1:0]    bits_left_q, bits_left_d;
  logic [CNT_W-1:0]    wb_q, wb_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;

  logic                issue;
  logic                last_bit;
  logic                start_ok;
  logic                accept;
  logic [CNT_W-1:0]    remaining;

  // Decode of per-edge activity shared by the FSM and the datapath.
  always_comb begin
    issue    = (state_q == StLoad) && (wb_q != '0);
    last_bit = issue && (bits_left_q == OneC);
    start_ok = START && ((state_q == StIdle) || (state_q == StDone));
  end

  // State register.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ABORT dominates everything.
  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (START) state_d = StLoad;
        StLoad:         if (last_bit) state_d = StFlush;
        StFlush:        state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state. IN_READY opens while the last held bit goes
  // out so a back-to-back stream never bubbles; an accept under ABORT is dropped.
  always_comb begin
    BUSY     = (state_q == StLoad);
    DONE     = (state_q == StDone);
    IN_READY = (state_q == StLoad) && (bits_left_q > wb_q) &&
               ((wb_q == '0) || ((wb_q == OneC) && issue));
  end

  assign HEAD      = head_q;
  assign SHIFT_EN  = shift_en_q;
  assign BITS_LEFT = bits_left_q;

  // Datapath next-state: issue one bit per edge, then refill from an accepted word.
  always_comb begin
    head_d      = head_q;
    shift_en_d  = 1'b0;
    bits_left_d = bits_left_q;
    wb_d        = wb_q;
    shreg_d     = shreg_q;
    remaining   = bits_left_q;
    accept      = IN_VALID && IN_READY && !ABORT;
    if (ABORT) begin
      head_d      = 1'b0;
      bits_left_d = '0;
      wb_d        = '0;
      shreg_d     = '0;
    end else if (start_ok) begin
      bits_left_d = ChainLenC;
      wb_d        = '0;
    end else if (state_q == StLoad) begin
      if (issue) begin
        head_d      = shreg_q[0];
        shift_en_d  = 1'b1;
        shreg_d     = shreg_q >> 1;
        wb_d        = wb_q - OneC;
        remaining   = bits_left_q - OneC;
        bits_left_d = remaining;
      end
      if (accept) begin
        shreg_d = IN_DATA;
        // Bits past the end of the chain are simply never counted.
        wb_d    = (remaining > WordCapC) ? WordCapC : remaining;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      bits_left_q <= '0;
      wb_q        <= '0;
      shreg_q     <= '0;
    end else begin
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      bits_left_q <= bits_left_d;
      wb_q        <= wb_d;
      shreg_q     <= shreg_d;
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the loader.
module tb_config_chain_loader;
  localparam int CL = 20;
  localparam int WW = 8;
  localparam int CW = $clog2(CL + 1);
  // Pulse k's HEAD value is bit k: 0xA5, 0x3C, then low nibble of 0xFF.
  localparam logic [19:0] ExpHeads = 20'hF3CA5;

  logic          CK = 1'b0;
  logic          RSTN = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [WW-1:0] IN_DATA = '0;
  logic          IN_READY, HEAD, SHIFT_EN, BUSY, DONE;
  logic [CW-1:0] BITS_LEFT;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;
  logic [7:0] words [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h11, 8'h22};

  bit sen_hist[$];
  bit head_hist[$];
  bit done_hist[$];
  int left_hist[$];

  always #5 CK = ~CK;

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .CK(CK), .RSTN(RSTN), .START(START), .ABORT(ABORT), .IN_DATA(IN_DATA),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .HEAD(HEAD), .SHIFT_EN(SHIFT_EN),
    .BUSY(BUSY), .DONE(DONE), .BITS_LEFT(BITS_LEFT)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: mode, bits still owed to the chain, and a queue of held bits.
  localparam int MIdle = 0, MLoad = 1, MFlush = 2, MDone = 3;
  int m_state = MIdle;
  int m_left = 0;
  bit m_head = 1'b0;
  bit m_sen = 1'b0;
  bit pend[$];

  function automatic bit m_ready();
    return (m_state == MLoad) && (m_left > pend.size()) && (pend.size() <= 1);
  endfunction

  always @(posedge CK or negedge RSTN) begin
    bit rdy;
    int n;
    if (!RSTN) begin
      m_state = MIdle; m_left = 0; m_head = 1'b0; m_sen = 1'b0; pend.delete();
    end else begin
      rdy = m_ready();
      m_sen = 1'b0;
      if (ABORT) begin
        m_state = MIdle; m_left = 0; m_head = 1'b0; pend.delete();
      end else begin
        case (m_state)
          MIdle, MDone: if (START) begin m_state = MLoad; m_left = CL; pend.delete(); end
          MLoad: begin
            if (pend.size() > 0) begin
              m_head = pend.pop_front(); m_sen = 1'b1; m_left--;
              if (m_left == 0) m_state = MFlush;
            end
            if (IN_VALID && rdy) begin
              n = (m_left < WW) ? m_left : WW;
              for (int i = 0; i < n; i++) pend.push_back(IN_DATA[i]);
            end
          end
          MFlush: m_state = MDone;
          default: ;
        endcase
      end
    end
  end

  // Compare process plus history for the directed checks.
  always @(negedge CK) begin
    if (cmp_en) begin
      chk("head", HEAD, m_head);
      chk("shift_en", SHIFT_EN, m_sen);
      chk("busy", BUSY, m_state == MLoad);
      chk("done", DONE, m_state == MDone);
      chk("bits_left", BITS_LEFT, m_left);
      chk("in_ready", IN_READY, m_ready());
      sen_hist.push_back(SHIFT_EN);
      head_hist.push_back(HEAD);
      done_hist.push_back(DONE);
      left_hist.push_back(int'(BITS_LEFT));
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic clear_hist();
    sen_hist.delete(); head_hist.delete(); done_hist.delete(); left_hist.delete();
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Feeds words; optionally withholds valid for gap_len ready cycles before
  // word gap_word, pulses START at cycle start_at, or aborts after N pulses.
  task automatic stream(input int nwords, input int gap_word, input int gap_len,
                        input int start_at, input int abort_after, input int max_cycles,
                        input bit want_done, output int accepts);
    int idx, skip, np;
    bit hs;
    idx = 0; skip = gap_len; np = 0; accepts = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (DONE) break;
      if (abort_after >= 0 && np >= abort_after) begin
        START = 1'b0; ABORT = 1'b1; IN_VALID = 1'b0;
        tick();
        ABORT = 1'b0;
        return;
      end
      START = (c == start_at);
      if (idx < nwords) begin
        if (idx == gap_word && skip > 0 && IN_READY) begin
          IN_VALID = 1'b0; skip--;
        end else begin
          IN_VALID = 1'b1; IN_DATA = words[idx];
        end
      end else begin
        IN_VALID = 1'b0;
      end
      hs = IN_VALID && IN_READY;
      tick();
      if (hs) begin idx++; accepts++; end
      if (SHIFT_EN) np++;
    end
    START = 1'b0;
    IN_VALID = 1'b0;
    if (want_done) chk("load_done", DONE, 1);
  endtask

  task automatic check_load(input int exp_gap, input int exp_gap_left);
    int first, last, np, gaps, badleft;
    logic [19:0] got;
    tick();
    first = -1; last = -1; np = 0; gaps = 0; badleft = 0; got = '0;
    foreach (sen_hist[i]) begin
      if (sen_hist[i]) begin
        if (first < 0) first = i;
        last = i;
        if (np < 20) got[np] = head_hist[i];
        np++;
      end
    end
    for (int i = first + 1; i < last; i++) begin
      if (!sen_hist[i]) begin
        gaps++;
        if (left_hist[i] != exp_gap_left) badleft++;
      end
    end
    chk("pulse_count", np, CL);
    chk("head_seq", got, ExpHeads);
    chk("pulse_gap", gaps, exp_gap);
    if (exp_gap > 0) chk("gap_bits_left_off", badleft, 0);
    chk("done_in_flush", (last >= 0) ? done_hist[last] : 1'b1, 0);
    chk("done_after_flush",
        (last >= 0 && last + 1 < done_hist.size()) ? done_hist[last + 1] : 1'b0, 1);
  endtask

  initial begin
    int acc;
    tick();
    cmp_en = 1'b1;
    tick();
    RSTN = 1'b1;
    tick();

    // T1: async reset mid-stream
    clear_hist();
    pulse_start();
    stream(5, -1, 0, -1, -1, 6, 1'b0, acc);
    RSTN = 1'b0;
    #1;
    chk("rst_head", HEAD, 0);
    chk("rst_shift_en", SHIFT_EN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_bits_left", BITS_LEFT, 0);
    chk("rst_in_ready", IN_READY, 0);
    tick();
    RSTN = 1'b1;
    tick();
    chk("post_rst_in_ready", IN_READY, 0);
    chk("post_rst_busy", BUSY, 0);

    // T2: continuous stream, extra words offered
    clear_hist();
    pulse_start();
    stream(5, -1, 0, -1, -1, 100, 1'b1, acc);
    chk("accepts", acc, 3);
    check_load(0, 0);

    // T3: five-cycle valid gap before word 1
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    clear_hist();
    pulse_start();
    stream(3, 1, 5, -1, -1, 100, 1'b1, acc);
    check_load(5, 12);

    // T4: abort after 10 bits, then a fresh load
    clear_hist();
    pulse_start();
    stream(5, -1, 0, -1, 10, 100, 1'b0, acc);
    chk("abort_shift_en", SHIFT_EN, 0);
    chk("abort_bits_left", BITS_LEFT, 0);
    chk("abort_done", DONE, 0);
    chk("abort_busy", BUSY, 0);
    clear_hist();
    pulse_start();
    stream(5, -1, 0, -1, -1, 100, 1'b1, acc);
    check_load(0, 0);

    // T5: START+ABORT in IDLE, START during LOAD
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    START = 1'b1; ABORT = 1'b1; tick(); START = 1'b0; ABORT = 1'b0;
    chk("sa_busy", BUSY, 0);
    chk("sa_bits_left", BITS_LEFT, 0);
    clear_hist();
    pulse_start();
    stream(5, -1, 0, 5, -1, 100, 1'b1, acc);
    check_load(0, 0);

    // T6: no accepts in DONE, restart from DONE
    IN_VALID = 1'b1; IN_DATA = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      chk("done_in_ready", IN_READY, 0);
      tick();
    end
    IN_VALID = 1'b0;
    START = 1'b1; tick(); START = 1'b0;
    chk("restart_bits_left", BITS_LEFT, CL);
    chk("restart_done", DONE, 0);
    chk("restart_busy", BUSY, 1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      START = ($urandom_range(0, 15) == 0);
      ABORT = ($urandom_range(0, 79) == 0);
      IN_VALID = ($urandom_range(0, 9) < 7);
      IN_DATA = WW'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2;
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
      end else begin
        tick();
      end
    end
    START = 1'b0; ABORT = 1'b0; IN_VALID = 1'b0;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
